// File: rtl/apb_master_bridge.sv
// APB4 requester: valid/ready command stream in, one APB transfer to one of NSLV
// completers, valid/ready response out. Adds decode errors, PSLVERR capture and a wait-state timeout.
module apb_master_bridge #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int NSLV      = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDRWIDTH-1:0]        cmd_addr,
  input  logic [DATAWIDTH-1:0]        cmd_wdata,
  input  logic [DATAWIDTH/8-1:0]      cmd_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATAWIDTH-1:0]        rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  output logic [NSLV-1:0]             PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [ADDRWIDTH-1:0]        PADDR,
  output logic [DATAWIDTH-1:0]        PWDATA,
  output logic [DATAWIDTH/8-1:0]      PSTRB,
  input  logic [NSLV*DATAWIDTH-1:0]   PRDATA,
  input  logic [NSLV-1:0]             PREADY,
  input  logic [NSLV-1:0]             PSLVERR
);

  localparam int SELW  = $clog2(NSLV);
  localparam int STRBW = DATAWIDTH / 8;
  localparam int CNTW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SELW:0]   NSLV_W  = (SELW + 1)'(NSLV);
  localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state, state_next;
  logic [SELW-1:0]     idx, idx_next;
  logic [CNTW-1:0]     wait_cnt, wait_cnt_next;

  logic                cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATAWIDTH-1:0] rsp_rdata_d, pwdata_d;
  logic [NSLV-1:0]     psel_d;
  logic                penable_d, pwrite_d;
  logic [ADDRWIDTH-1:0] paddr_d;
  logic [STRBW-1:0]    pstrb_d;

  logic [SELW-1:0]     cmd_idx;
  logic                cmd_idx_ok, cmd_hs, rsp_hs;
  logic                sel_ready, sel_err, timeout_hit;
  logic [DATAWIDTH-1:0] prdata_arr [NSLV];
  logic [DATAWIDTH-1:0] sel_rdata;

  assign cmd_idx    = cmd_addr[ADDRWIDTH-1 -: SELW];
  assign cmd_idx_ok = {1'b0, cmd_idx} < NSLV_W;
  assign cmd_hs     = cmd_valid & cmd_ready;
  assign rsp_hs     = rsp_valid & rsp_ready;

  always_comb begin
    for (int unsigned i = 0; i < NSLV; i++) begin
      prdata_arr[i] = PRDATA[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Only the selected completer's handshake inputs are ever looked at.
  assign sel_ready   = PREADY[idx];
  assign sel_err     = PSLVERR[idx];
  assign sel_rdata   = prdata_arr[idx];
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      wait_cnt    <= wait_cnt_next;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_rdata   <= rsp_rdata_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
    end
  end

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          idx_next      = cmd_idx;
          wait_cnt_next = '0;
          state_next    = cmd_idx_ok ? SETUP : RESP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (sel_ready || timeout_hit) begin
          state_next = RESP;
        end else if (wait_cnt != '1) begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d   = (state_next == IDLE);
    rsp_valid_d   = rsp_valid;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    rsp_rdata_d   = rsp_rdata;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;
    case (state)
      IDLE: begin
        if (cmd_hs && cmd_idx_ok) begin
          psel_d   = NSLV'(1) << cmd_idx;
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          pstrb_d  = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (state_next == RESP) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = sel_ready ? sel_err : 1'b1;
          rsp_timeout_d = !sel_ready;
          rsp_rdata_d   = (sel_ready && !PWRITE && !sel_err) ? sel_rdata : '0;
        end
      end
      RESP: begin
        // Decode errors enter RESP with rsp_valid still low; raise it one cycle later.
        if (!rsp_valid) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end else if (rsp_hs) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule
